// File: rtl/edge_evt_pkg.sv
// Shared types and defaults for the edge event capture block.
// Latency: none (types and constants only).
// Backpressure: n/a.
package edge_evt_pkg;

    localparam int TS_W_DEF        = 16;
    localparam int DEPTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // One captured edge: polarity plus the timestamp of its detection cycle.
    typedef struct packed {
        logic                rise;
        logic [TS_W_DEF-1:0] ts;
    } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous event FIFO with a registered head and occupancy count.
// Latency: a push into an empty FIFO shows at the head one cycle later (no bypass).
// Backpressure: push while full without a pop is dropped; push+pop while full is accepted.
module evt_fifo
    import edge_evt_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = evt_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  T                         i_push_dat,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output T                         o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_pop;
    logic            w_push;

    // Full/empty come from the count so the pointers may freely wrap modulo DEPTH.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop on empty is ignored; a full FIFO only takes a push when it pops in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage, pointers and occupancy; when full, push+pop reuses the slot being vacated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/edge_event_capture.sv
// Synchronizes an async level, timestamps its rising/falling edges and queues them.
// Latency: sig_in set before posedge k -> event pushed at posedge k+SYNC_STAGES, evt_valid after it.
// Backpressure: evt_valid/evt_ready drain; events arriving on a full, non-popping FIFO are dropped and flagged.
module edge_event_capture
    import edge_evt_pkg::*;
#(
    parameter int TS_W        = TS_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sig_in,
    input  logic                     en,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     evt_rise,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    // Event layout sized to this instance's timestamp width.
    typedef struct packed {
        logic            rise;
        logic [TS_W-1:0] ts;
    } cap_evt_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [TS_W-1:0]        r_ts;
    logic                   r_ovf;
    logic                   w_s;
    logic                   w_edge;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    cap_evt_t               w_evt;
    cap_evt_t               w_head;

    assign w_s    = r_sync[SYNC_STAGES-1];
    // prev follows s even while disabled, so re-enabling never sees a stale level difference.
    assign w_edge = (w_s != r_prev) && en;
    assign w_evt  = '{rise: w_s, ts: r_ts};
    assign w_pop  = evt_valid && evt_ready;

    // Plain flop chain for the asynchronous input: nothing may sit between the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Previous synchronized level for edge detection, tracked every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_s;
        end
    end

    // Free-running timestamp; an event samples the value before this cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else if (en) begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_edge && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .T     (cap_evt_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_edge),
        .i_push_dat (w_evt),
        .i_pop      (evt_ready),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (evt_count),
        .o_head     (w_head)
    );

    assign evt_valid = !w_empty;
    assign evt_rise  = w_head.rise;
    assign evt_ts    = w_head.ts;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_edge_event_capture.sv
module tb_edge_event_capture;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic        clk;
    logic        rst_n, sig_in, en, evt_ready, clr_ovf;
    logic        evt_valid, evt_rise, overflow;
    logic [15:0] evt_ts;
    logic [2:0]  evt_count;

    logic        rst2_n, sig2, en2, rdy2, clr2;
    logic        vld2, rise2, ovf2;
    logic [3:0]  ts2;
    logic [2:0]  cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model state (spec-level behaviour of the main instance).
    logic [SYNC-1:0] m_hist;
    logic            m_prev;
    logic [15:0]     m_ts;
    logic            m_ovf;
    logic [16:0]     exp_q[$];

    edge_event_capture #(.TS_W(16), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) u_dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_rise(evt_rise),
        .evt_ts(evt_ts), .evt_count(evt_count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    edge_event_capture #(.TS_W(4), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) u_wrap (
        .clk(clk), .rst_n(rst2_n), .sig_in(sig2), .en(en2),
        .evt_valid(vld2), .evt_ready(rdy2), .evt_rise(rise2),
        .evt_ts(ts2), .evt_count(cnt2), .overflow(ovf2), .clr_ovf(clr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard predictor: pushes expected events as the stimulus creates them.
    initial begin
        logic m_s, do_pop, do_edge;
        m_hist = '0; m_prev = 1'b0; m_ts = '0; m_ovf = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hist = '0; m_prev = 1'b0; m_ts = '0; m_ovf = 1'b0;
                exp_q.delete();
            end else begin
                m_s     = m_hist[SYNC-1];
                do_pop  = evt_ready && (exp_q.size() > 0);
                do_edge = (m_s != m_prev) && en;
                if (do_pop) void'(exp_q.pop_front());
                if (do_edge && exp_q.size() >= DEPTH) m_ovf = 1'b1;
                else if (clr_ovf) m_ovf = 1'b0;
                if (do_edge && exp_q.size() < DEPTH) exp_q.push_back({m_s, m_ts});
                m_prev = m_s;
                m_hist = {m_hist[SYNC-2:0], sig_in};
                if (en) m_ts = m_ts + 16'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", {31'd0, evt_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        chk("count", {29'd0, evt_count}, exp_q.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (exp_q.size() > 0) begin
            chk("head_rise", {31'd0, evt_rise}, {31'd0, exp_q[0][16]});
            chk("head_ts", {16'd0, evt_ts}, {16'd0, exp_q[0][15:0]});
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int   prev_ts;
        logic last_lvl;
        rst_n = 1'b1; rst2_n = 1'b0;
        sig_in = 1'b0; en = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
        sig2 = 1'b0; en2 = 1'b0; rdy2 = 1'b0; clr2 = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_count", {29'd0, evt_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_rise", {31'd0, evt_rise}, 32'd0);
        chk("rst_ts", {16'd0, evt_ts}, 32'd0);
        #1 rst_n = 1'b1;

        // First rising edge: setup before posedge 3, event after posedge 5 with ts 2
        step(); step();
        en = 1'b1; sig_in = 1'b1;
        step();
        step();
        chk("lat_not_yet", {31'd0, evt_valid}, 32'd0);
        step();
        chk("lat_valid", {31'd0, evt_valid}, 32'd1);
        chk("lat_rise", {31'd0, evt_rise}, 32'd1);
        chk("lat_ts", {16'd0, evt_ts}, 32'd2);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("pop_empty", {31'd0, evt_valid}, 32'd0);

        // Edge while disabled: no event, ts frozen at 4, no spurious event on re-enable
        sig_in = 1'b0; en = 1'b0;
        repeat (6) step();
        en = 1'b1;
        repeat (4) step();
        chk("no_spurious", {31'd0, evt_valid}, 32'd0);
        sig_in = 1'b1;
        repeat (3) step();
        chk("frozen_ts", {16'd0, evt_ts}, 32'd10);
        chk("frozen_rise", {31'd0, evt_rise}, 32'd1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;

        // Six edges without draining: four kept, overflow set
        for (int i = 0; i < 6; i++) begin
            sig_in = ~sig_in;
            step(); step();
        end
        repeat (3) step();
        chk("ovf_count", {29'd0, evt_count}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        prev_ts = -1;
        for (int i = 0; i < 4; i++) begin
            chk("order_rise", {31'd0, evt_rise}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("order_ts", (int'(evt_ts) > prev_ts) ? 32'd1 : 32'd0, 32'd1);
            prev_ts = int'(evt_ts);
            evt_ready = 1'b1;
            step();
        end
        evt_ready = 1'b0;
        chk("drained", {31'd0, evt_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO: push and pop in the same cycle is accepted
        for (int i = 0; i < 4; i++) begin
            sig_in = ~sig_in;
            step(); step();
        end
        repeat (2) step();
        chk("full_count", {29'd0, evt_count}, 32'd4);
        sig_in = ~sig_in;
        last_lvl = sig_in;
        step();
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("pp_count", {29'd0, evt_count}, 32'd4);
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("pp_last", {31'd0, evt_rise}, {31'd0, last_lvl});
            evt_ready = 1'b1;
            step();
        end
        evt_ready = 1'b0;

        // Async reset mid-burst with three events queued
        for (int i = 0; i < 3; i++) begin
            sig_in = ~sig_in;
            step(); step();
        end
        repeat (2) step();
        chk("burst_count", {29'd0, evt_count}, 32'd3);
        #1 rst_n = 1'b0; sig_in = 1'b0;
        #1;
        chk("arst_valid", {31'd0, evt_valid}, 32'd0);
        chk("arst_count", {29'd0, evt_count}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        #2 rst_n = 1'b1;
        repeat (5) step();
        chk("no_stale", {31'd0, evt_valid}, 32'd0);

        // 4-bit timestamp wrap: events at ts 15 then 1
        rst2_n = 1'b1; en2 = 1'b1;
        repeat (13) @(negedge clk);
        sig2 = 1'b1;
        repeat (2) @(negedge clk);
        sig2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_count", {29'd0, cnt2}, 32'd2);
        chk("wrap_rise0", {31'd0, rise2}, 32'd1);
        chk("wrap_ts0", {28'd0, ts2}, 32'd15);
        rdy2 = 1'b1;
        @(negedge clk);
        rdy2 = 1'b0;
        chk("wrap_rise1", {31'd0, rise2}, 32'd0);
        chk("wrap_ts1", {28'd0, ts2}, 32'd1);
        rdy2 = 1'b1;
        @(negedge clk);
        rdy2 = 1'b0;
        chk("wrap_empty", {31'd0, vld2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_event_capture.md
Name: edge_event_capture

Overview:
- Downstream consumer of the toggle/OR stage.
- Takes its asynchronous, delay-skewed output `sig_in` (a continuous-assign output with transport delay, so not aligned to `clk`) and synchronizes it.
- Detects rising and falling edges and timestamps each edge with a free-running cycle counter.
- Buffers the events in a small FIFO, drained through a valid/ready interface toward a logger/checker.

Parameters:
TS_W, 16, timestamp counter width (bits)
DEPTH, 4, event FIFO depth (power of 2, >=2)
SYNC_STAGES, 2, synchronizer flop count (>=2)

Ports:
clk  input  1  sole clock, posedge active
rst_n  input  1  reset; asynchronous assert, active-low
sig_in  input  1  asynchronous level from upstream OR stage
en  input  1  capture enable
evt_valid  output  1  FIFO head holds an event
evt_ready  input  1  consumer accepts head when high with evt_valid
evt_rise  output  1  head event polarity: 1 = rising, 0 = falling
evt_ts  output  TS_W  head event timestamp
evt_count  output  $clog2(DEPTH)+1  FIFO occupancy
overflow  output  1  sticky: an event was dropped
clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Interface decision: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values, applied immediately on `rst_n` low:
  - all sync flops = 0, prev level = 0
  - ts = 0, FIFO empty
  - evt_valid = 0, evt_rise = 0, evt_ts = 0, evt_count = 0, overflow = 0
- Reset mid-operation discards all queued events.
- Synchronizer: `sig_in` passes through SYNC_STAGES flops. `s` denotes the last stage. No logic between the flops.
- Edge detect:
  - prev <= s every cycle, regardless of en.
  - edge = (s != prev) && en.
  - rise = s.
  - A pulse shorter than one clk may be missed; this is acceptable.
- Timestamp:
  - ts increments by 1 each cycle en = 1 and holds when en = 0.
  - Wraps from 2^TS_W-1 to 0 silently.
  - An event records the ts value of the detection cycle, i.e. the pre-increment value.
- Latency:
  - sig_in stable before posedge k gives s updated at posedge k+SYNC_STAGES-1.
  - The event is pushed at posedge k+SYNC_STAGES.
  - evt_valid = 1 after that edge.
- FIFO:
  - Registered head: evt_rise/evt_ts valid whenever evt_valid.
  - Pop when evt_valid && evt_ready.
  - evt_rise/evt_ts hold stable while evt_valid && !evt_ready.
  - evt_count is updated each edge: +1 push, -1 pop, unchanged for both or neither.
- Full:
  - Push with count == DEPTH and no pop: event dropped, overflow <= 1.
  - Push and pop in the same cycle while full: accepted, count stays DEPTH.
- Empty: pop impossible (evt_valid = 0); evt_ready is ignored.
- Push into an empty FIFO: evt_valid rises the next cycle (no bypass).
- Overflow:
  - Sticky until clr_ovf = 1 at an edge.
  - Drop and clr_ovf in the same cycle: overflow = 1 (set wins).
- en deasserted:
  - No events, ts frozen.
  - prev keeps tracking s, so no spurious event is produced on re-enable.
  - FIFO still drains.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by the count, not pointer equality.

Decomposition:
- Package `edge_evt_pkg`:
  - `evt_t` packed struct {rise, ts[TS_W-1:0]}
  - default constants TS_W_DEF = 16, DEPTH_DEF = 4
- One sub-module, `evt_fifo`:
  - Parameterized on DEPTH and the `evt_t` type.
  - Ports: push/evt_t in, pop, full, empty, count, head.
- The synchronizer stays inline.

Test Plan:
- Reset, then sig_in 0->1 setup before posedge 3 with en = 1 -> evt_valid rises after posedge 5, evt_rise = 1, evt_ts = 2.
- sig_in 1->0 while en = 0, then en = 1 -> no event; evt_valid stays 0 and ts is frozen at its value when en dropped.
- Six edges, evt_ready = 0 -> evt_count = 4, overflow = 1 after the 5th edge is detected; the first 4 events are intact and in order (rise, fall alternating, increasing ts).
- FIFO full, an edge pushes in the same cycle evt_ready = 1 -> count stays 4, overflow stays 0, new event appears last.
- TS_W = 4: edge detected at ts = 15, next at ts = 1 -> evt_ts values 15 then 1 (wrap).
- rst_n low for 3 ns mid-burst with 3 events queued -> evt_valid, evt_count and overflow go to 0 immediately without a clock edge; no stale events after release.
